uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
Serial UART transmitter with a small input FIFO. It sits directly upstream of uart_rx and drives that block's rx_data_in line. The frame format matches uart_rx: 1 start bit (0), 8 data bits LSB first, 1 even-parity bit, 1 stop bit (1). Bytes are accepted over a valid/ready handshake, buffered, and serialised back-to-back.

Parameters:
CLKS_PER_BIT, 1, clock cycles each serial bit is held; must be ≥1. The default of 1 matches uart_rx's one-bit-per-clock sampling.
DEPTH, 4, FIFO entries; must be a power of 2, ≥2.
PARITY_ODD, 0, 0 = even parity (uart_rx compatible); 1 = odd parity.

Ports:
clk  input  1  system clock; all logic on the rising edge
reset  input  1  synchronous, active-high reset
tx_data_in  input  8  byte to transmit
tx_valid  input  1  tx_data_in is valid this cycle
tx_ready  output  1  FIFO can accept; a push occurs when tx_valid && tx_ready at a rising edge
tx_data_out  output  1  serial line, idle high; connects to uart_rx.rx_data_in
tx_busy  output  1  high while a frame is on the line (state != IDLE)
fifo_count  output  $clog2(DEPTH)+1  bytes held in the FIFO, excluding the byte being shifted

Behaviour:
- Reset values, applied at a clock edge while reset=1:
  - tx_data_out=1, tx_busy=0, fifo_count=0.
  - FIFO pointers cleared; state=IDLE; counters 0.
  - tx_ready=0 while reset is high.
- tx_ready = !reset && (fifo_count != DEPTH). It is combinational from registered state only; no dependence on tx_valid.
- FIFO behaviour:
  - Push: write at the write pointer, pointer wraps modulo DEPTH, count+1.
  - Pop: occurs only when the FSM loads a byte.
  - Same-cycle push and pop: count unchanged.
  - When full, tx_ready=0 and pushes are ignored, even if a pop happens that cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Counters:
  - baud_cnt runs 0..CLKS_PER_BIT-1; a bit boundary occurs when baud_cnt == CLKS_PER_BIT-1.
  - bit_idx runs 0..7.
- IDLE: tx_data_out=1. If fifo_count>0 at an edge: pop into shift register shreg, compute parity = ^byte ^ PARITY_ODD, go to START, and drive tx_data_out<=0 on that same edge.
- START: hold 0 for CLKS_PER_BIT cycles, then go to DATA with tx_data_out<=shreg[0], bit_idx=0.
- DATA: each bit boundary shifts shreg right and outputs the next bit. After bit 7's period, go to PARITY and output the parity bit.
- PARITY: hold for CLKS_PER_BIT cycles, then go to STOP and output 1.
- STOP: hold 1 for CLKS_PER_BIT cycles. At the end:
  - If fifo_count>0: pop and go directly to START (no idle gap; the next start bit follows immediately).
  - Else: go to IDLE.
- Frame length is exactly 11*CLKS_PER_BIT cycles.
- Latency: a byte pushed at edge E into an empty FIFO with FSM idle is popped at edge E+1; the start bit appears on tx_data_out from edge E+1.
- tx_busy is registered: set on the edge that enters START, cleared on the edge that enters IDLE.
- tx_data_out is a flop output (glitch-free).
- Reset mid-frame: at the next edge the line returns to 1, the frame is abandoned, and the FIFO is flushed. The partial frame is not resumed.
- tx_data_in changes while not handshaked have no effect. Data is captured only on a push.

Test Plan:
- CLKS_PER_BIT=1, push 0xAD once → line from pop edge: 0,1,0,1,1,0,1,0,1,1(parity),1(stop), then idle 1; tx_busy high exactly 11 cycles.
- Loopback into uart_rx: push 0x3C then 0xE1 → parity bits 0 and 0; rx_data_out shows 0x3C then 0xE1; parity_error=0, stop_error=0 throughout.
- Burst: hold tx_valid with bytes 0x01..0x06 while idle.
  - Required: tx_ready drops when fifo_count=4.
  - Then: pushes resume as frames pop.
  - Then: six contiguous frames, 66 cycles total, with no idle bit between frames.
  - Then: all six bytes are received in order.
- CLKS_PER_BIT=4, push 0xE1 → every bit is held 4 cycles; frame 44 cycles; sampled bits 0,1,0,0,0,0,1,1,1,0,1.
- Assert reset for 1 cycle during DATA bit 3 of 0xAD with 2 bytes queued → line is 1 at the next edge; fifo_count=0, tx_busy=0; no further frames are sent.
- PARITY_ODD=1, push 0xAD → parity bit is 0; a push of 0x00 gives parity bit 1.

Source files
------------

// File: rtl/uart_tx.sv
// Serial UART transmitter (start, 8 data LSB first, parity, stop) fed by a small byte FIFO.
// Drives the uart_rx line directly; frames are sent back-to-back while the FIFO holds data.

// Generic synchronous FIFO with occupancy count and a combinational read port.
// Latency: a pushed entry is visible on pop_dat one edge after the push.
// Backpressure: push_rdy low when full or in reset; a push into a full FIFO is dropped even alongside a pop.
module uart_tx_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_vld,
    input  logic [W-1:0]             push_dat,
    output logic                     push_rdy,
    input  logic                     pop_vld,
    output logic [W-1:0]             pop_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_fire;
    logic          pop_fire;

    assign push_rdy  = !reset && (count != CW'(DEPTH));
    assign push_fire = push_vld && push_rdy;
    assign pop_fire  = pop_vld && (count != '0);
    assign pop_dat   = mem[rd_ptr];

    // Storage carries no reset; push_rdy is low during reset so nothing is written.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_fire) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_fire) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_fire, pop_fire})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// UART transmitter: FIFO-buffered bytes serialised as 11-bit frames, each bit held CLKS_PER_BIT cycles.
// Latency: byte pushed at edge E into an empty, idle block puts its start bit on the line from edge E+1.
// Backpressure: tx_ready follows FIFO space only (never tx_valid); the next frame starts right after a stop bit.
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter int unsigned DEPTH        = 4,
    parameter bit          PARITY_ODD   = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [7:0]                 tx_data_in,
    input  logic                       tx_valid,
    output logic                       tx_ready,
    output logic                       tx_data_out,
    output logic                       tx_busy,
    output logic [$clog2(DEPTH):0]     fifo_count
);
    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   baud_cnt;
    logic [CNT_W-1:0]   baud_nxt;
    logic [2:0]         bit_idx;
    logic [2:0]         idx_nxt;
    logic [7:0]         shreg;
    logic [7:0]         shreg_nxt;
    logic               par_bit;
    logic               par_nxt;
    logic               line_nxt;
    logic               busy_nxt;
    logic               load;
    logic               pop_vld;
    logic [7:0]         pop_dat;
    logic               bit_end;
    logic               fifo_nempty;

    uart_tx_fifo #(
        .W     (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push_vld (tx_valid),
        .push_dat (tx_data_in),
        .push_rdy (tx_ready),
        .pop_vld  (pop_vld),
        .pop_dat  (pop_dat),
        .count    (fifo_count)
    );

    assign fifo_nempty = (fifo_count != '0);
    assign bit_end     = (baud_cnt == BAUD_LAST);

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        idx_nxt   = bit_idx;
        shreg_nxt = shreg;
        par_nxt   = par_bit;
        line_nxt  = tx_data_out;
        busy_nxt  = tx_busy;
        load      = 1'b0;
        pop_vld   = 1'b0;

        if (state != IDLE) begin
            baud_nxt = bit_end ? '0 : baud_cnt + CNT_W'(1);
        end

        case (state)
            IDLE: begin
                line_nxt = 1'b1;
                load     = fifo_nempty;
            end
            START: begin
                if (bit_end) begin
                    state_nxt = DATA;
                    idx_nxt   = 3'd0;
                    line_nxt  = shreg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == 3'd7) begin
                        state_nxt = PARITY;
                        line_nxt  = par_bit;
                    end else begin
                        idx_nxt   = bit_idx + 3'd1;
                        shreg_nxt = {1'b0, shreg[7:1]};
                        line_nxt  = shreg[1];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_nxt = STOP;
                    line_nxt  = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (fifo_nempty) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        line_nxt  = 1'b1;
                        busy_nxt  = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                line_nxt  = 1'b1;
                busy_nxt  = 1'b0;
            end
        endcase

        // Loading a byte starts the start bit on the same edge, from IDLE or straight out of STOP.
        if (load) begin
            pop_vld   = 1'b1;
            shreg_nxt = pop_dat;
            par_nxt   = (^pop_dat) ^ PARITY_ODD;
            state_nxt = START;
            baud_nxt  = '0;
            line_nxt  = 1'b0;
            busy_nxt  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            baud_cnt    <= '0;
            bit_idx     <= 3'd0;
            shreg       <= 8'd0;
            par_bit     <= 1'b0;
            tx_data_out <= 1'b1;
            tx_busy     <= 1'b0;
        end else begin
            state       <= state_nxt;
            baud_cnt    <= baud_nxt;
            bit_idx     <= idx_nxt;
            shreg       <= shreg_nxt;
            par_bit     <= par_nxt;
            tx_data_out <= line_nxt;
            tx_busy     <= busy_nxt;
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (1 clk/bit even, 4 clks/bit even, 1 clk/bit odd) checked
// cycle by cycle against a frame-level model, plus a line decoder standing in for uart_rx.
module tb_uart_tx;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [7:0]    d0, d1, d2;
    logic          v0, v1, v2;
    logic          r0, r1, r2;
    logic          l0, l1, l2;
    logic          b0, b1, b2;
    logic [CW-1:0] c0, c1, c2;

    uart_tx #(.CLKS_PER_BIT(1), .DEPTH(DEPTH), .PARITY_ODD(1'b0)) u_even1 (
        .clk(clk), .reset(reset), .tx_data_in(d0), .tx_valid(v0), .tx_ready(r0),
        .tx_data_out(l0), .tx_busy(b0), .fifo_count(c0));
    uart_tx #(.CLKS_PER_BIT(4), .DEPTH(DEPTH), .PARITY_ODD(1'b0)) u_even4 (
        .clk(clk), .reset(reset), .tx_data_in(d1), .tx_valid(v1), .tx_ready(r1),
        .tx_data_out(l1), .tx_busy(b1), .fifo_count(c1));
    uart_tx #(.CLKS_PER_BIT(1), .DEPTH(DEPTH), .PARITY_ODD(1'b1)) u_odd1 (
        .clk(clk), .reset(reset), .tx_data_in(d2), .tx_valid(v2), .tx_ready(r2),
        .tx_data_out(l2), .tx_busy(b2), .fifo_count(c2));

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] src_q[$];
    logic [7:0] sent_q[$];
    logic [7:0] dec_q[$];
    logic       obs_q[$];
    int         obs_busy;
    int         busy_rises;
    int         dec_errs;
    bit         saw_full;
    logic       ad_line [11] = '{0, 1, 0, 1, 1, 0, 1, 0, 1, 1, 1};
    logic       e1_line [11] = '{0, 1, 0, 0, 0, 0, 1, 1, 1, 0, 1};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int i, input bit odd);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        if (i == 9) return (^b) ^ odd;
        return 1'b1;
    endfunction

    task automatic drive(input int sel, input logic v, input logic [7:0] d);
        case (sel)
            0: begin v0 = v; d0 = d; end
            1: begin v1 = v; d1 = d; end
            default: begin v2 = v; d2 = d; end
        endcase
    endtask

    task automatic sample(input int sel, output logic ln, output logic bz, output logic rd,
                          output logic [CW-1:0] ct);
        case (sel)
            0: begin ln = l0; bz = b0; rd = r0; ct = c0; end
            1: begin ln = l1; bz = b1; rd = r1; ct = c1; end
            default: begin ln = l2; bz = b2; rd = r2; ct = c2; end
        endcase
    endtask

    // Frame-level model: a byte queue, one frame of 11*clks cycles started whenever the line is free.
    task automatic run_model(input int sel, input int gap_pct, input int limit);
        int         clks = (sel == 1) ? 4 : 1;
        bit         odd = (sel == 2);
        logic [7:0] mq[$];
        int         next_free = 0;
        int         cur_start = 0;
        bit         cur_vld = 0;
        logic [7:0] cur_b = 8'h00;
        logic       exp_line = 1'b1;
        logic       exp_busy = 1'b0;
        logic       prev_bz = 1'b0;
        logic       ln, bz, rd;
        logic [CW-1:0] ct;
        logic       v;
        logic [7:0] d;
        bit         push, pop;
        bit         done = 0;
        obs_q.delete();
        sent_q.delete();
        obs_busy = 0;
        busy_rises = 0;
        saw_full = 0;
        for (int c = 0; c < limit && !done; c++) begin
            @(negedge clk);
            sample(sel, ln, bz, rd, ct);
            chk("line", ln, exp_line);
            chk("busy", bz, exp_busy);
            chk("fifo_count", ct, mq.size());
            chk("tx_ready", rd, mq.size() != DEPTH);
            obs_q.push_back(ln);
            if (bz) obs_busy++;
            if (bz && !prev_bz) busy_rises++;
            prev_bz = bz;
            if (!rd) saw_full = 1;
            v = (src_q.size() > 0) && ($urandom_range(99) >= gap_pct);
            d = v ? src_q[0] : 8'($urandom);
            drive(sel, v, d);
            push = v && (mq.size() != DEPTH);
            pop  = (c >= next_free) && (mq.size() > 0);
            if (pop) begin
                cur_b = mq.pop_front();
                cur_start = c;
                cur_vld = 1;
                next_free = c + 11 * clks;
            end
            if (push) begin
                mq.push_back(d);
                sent_q.push_back(d);
                void'(src_q.pop_front());
            end
            if (cur_vld && (c - cur_start) < 11 * clks) begin
                exp_line = frame_bit(cur_b, (c - cur_start) / clks, odd);
                exp_busy = 1'b1;
            end else begin
                exp_line = 1'b1;
                exp_busy = 1'b0;
            end
            done = (src_q.size() == 0) && (mq.size() == 0) && (c >= next_free + 2);
        end
        drive(sel, 1'b0, 8'h00);
        chk("drained_in_budget", done, 1);
    endtask

    // Receiver model: finds start bits and samples each bit at its centre.
    task automatic decode(input int clks, input bit odd);
        int i = 0;
        logic [7:0] b;
        dec_q.delete();
        dec_errs = 0;
        while (i + 11 * clks <= obs_q.size()) begin
            if (obs_q[i] == 1'b0) begin
                for (int k = 0; k < 8; k++) b[k] = obs_q[i + (k + 1) * clks + clks / 2];
                if (obs_q[i + 9 * clks + clks / 2] !== ((^b) ^ odd)) dec_errs++;
                if (obs_q[i + 10 * clks + clks / 2] !== 1'b1) dec_errs++;
                dec_q.push_back(b);
                i += 11 * clks;
            end else begin
                i++;
            end
        end
    endtask

    function automatic int first_zero();
        for (int i = 0; i < obs_q.size(); i++) if (obs_q[i] == 1'b0) return i;
        return 0;
    endfunction

    initial begin
        int idx;
        int n;
        reset = 1'b1;
        v0 = 0; v1 = 0; v2 = 0;
        d0 = 0; d1 = 0; d2 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", r0, 0);
        chk("reset_line", l0, 1);
        chk("reset_busy", b0, 0);
        chk("reset_count", c0, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_ready", r1, 1);
        chk("post_reset_line4", l1, 1);

        // Single 0xAD: exact line pattern, start bit two samples after the push cycle.
        src_q = '{8'hAD};
        run_model(0, 0, 200);
        idx = first_zero();
        chk("ad_start_latency", idx, 2);
        for (int k = 0; k < 11; k++) chk($sformatf("ad_bit%0d", k), obs_q[idx + k], ad_line[k]);
        chk("ad_busy_cycles", obs_busy, 11);

        // Loopback 0x3C, 0xE1.
        src_q = '{8'h3C, 8'hE1};
        run_model(0, 0, 200);
        decode(1, 0);
        chk("loop_count", dec_q.size(), 2);
        chk("loop_b0", dec_q[0], 8'h3C);
        chk("loop_b1", dec_q[1], 8'hE1);
        chk("loop_errs", dec_errs, 0);
        idx = first_zero();
        chk("loop_par0", obs_q[idx + 9], 0);
        chk("loop_par1", obs_q[idx + 20], 0);

        // Burst 0x01..0x06 with tx_valid held: full FIFO, 66 contiguous busy cycles.
        src_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        run_model(0, 0, 300);
        chk("burst_busy_cycles", obs_busy, 66);
        chk("burst_busy_rises", busy_rises, 1);
        chk("burst_saw_full", saw_full, 1);
        decode(1, 0);
        chk("burst_count", dec_q.size(), 6);
        for (int k = 0; k < 6; k++) chk($sformatf("burst_b%0d", k), dec_q[k], k + 1);
        chk("burst_errs", dec_errs, 0);

        // Four clocks per bit, 0xE1.
        src_q = '{8'hE1};
        run_model(1, 0, 300);
        chk("e1_busy_cycles", obs_busy, 44);
        idx = first_zero();
        for (int k = 0; k < 11; k++) chk($sformatf("e1_bit%0d", k), obs_q[idx + 4 * k + 2], e1_line[k]);
        decode(4, 0);
        chk("e1_count", dec_q.size(), 1);
        chk("e1_byte", dec_q[0], 8'hE1);

        // Odd parity: 0xAD gives 0, 0x00 gives 1.
        src_q = '{8'hAD, 8'h00};
        run_model(2, 0, 200);
        idx = first_zero();
        chk("odd_par_ad", obs_q[idx + 9], 0);
        chk("odd_par_00", obs_q[idx + 20], 1);
        decode(1, 1);
        chk("odd_count", dec_q.size(), 2);
        chk("odd_errs", dec_errs, 0);

        // Random bytes with random valid gaps on two instances.
        for (int s = 0; s < 2; s++) begin
            n = (s == 0) ? 24 : 6;
            src_q.delete();
            for (int k = 0; k < n; k++) src_q.push_back(8'($urandom));
            run_model(s, 40, 3000);
            decode((s == 0) ? 1 : 4, 0);
            chk("rand_count", dec_q.size(), n);
            for (int k = 0; k < n && k < dec_q.size(); k++)
                chk($sformatf("rand%0d_b%0d", s, k), dec_q[k], sent_q[k]);
            chk("rand_errs", dec_errs, 0);
        end

        // Reset during DATA bit 3 of 0xAD with two bytes queued behind it.
        @(negedge clk); v0 = 1; d0 = 8'hAD;
        @(negedge clk); d0 = 8'h11;
        @(negedge clk); d0 = 8'h22;
        @(negedge clk); v0 = 0; d0 = 8'h5A;
        @(negedge clk);
        chk("mid_bit1", l0, 0);
        repeat (2) @(negedge clk);
        chk("mid_count", c0, 2);
        chk("mid_busy", b0, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_line", l0, 1);
        chk("rst_count", c0, 0);
        chk("rst_busy", b0, 0);
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            chk("rst_quiet_line", l0, 1);
            chk("rst_quiet_busy", b0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
